// File: rtl/ofdm_frame_rx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_frame_rx_ctrl_pkg
//   Definitions shared by the OFDM frame receive controller and its FCH
//   parser: receive-state encodings (visible on o_state), FCH byte count and
//   bit positions, the BPSK modulation code used for the FCH symbol, and the
//   FCH field decode helper.
// ---------------------------------------------------------------------------
package ofdm_frame_rx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_CP       = 3'd2,
      ST_SYMBOL   = 3'd3,
      ST_DONE     = 3'd4
   } rx_state_t;

   // FCH is carried BPSK-modulated in symbol 0
   localparam int BPSK_MOD = 1;

   localparam int FCH_BYTES    = 3;
   // byte0 bit 6 is reserved and must be zero
   localparam int FCH_RSVD_BIT = 6;
   // byte0 bit 7 is the LSB of the repetition coding indicator
   localparam int FCH_REP_BIT  = 7;

   typedef struct packed {
      logic [7:0] data_frame_size;
      logic [2:0] coding_indicator;
      logic [1:0] repition_coding_indicator;
      logic [5:0] subchanale_bitmap;
      logic       error;
   } fch_fields_t;

   // Decode the three FCH bytes; error flags nonzero reserved bits
   // (byte0[6] and byte2[7:4]).
   function automatic fch_fields_t fch_decode(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2);
      fch_fields_t f;
      f.subchanale_bitmap         = b0[5:0];
      f.repition_coding_indicator = {b1[0], b0[FCH_REP_BIT]};
      f.coding_indicator          = b1[3:1];
      f.data_frame_size           = {b2[3:0], b1[7:4]};
      f.error                     = b0[FCH_RSVD_BIT] | (|b2[7:4]);
      return f;
   endfunction

endpackage

// File: rtl/ofdm_frame_rx_ctrl_fch_parser.sv
// ---------------------------------------------------------------------------
// ofdm_fch_parser
//   Captures the first three demapped FCH bytes of a frame, decodes the
//   header fields and raises fch_done / fch_error.
//   clk, reset        : clock, async active-high reset
//   clear             : accepted frame start; wipes all FCH state
//   active            : controller is inside a frame (not IDLE)
//   fch_valid/data    : demapped FCH byte stream
//   symbol_index      : symbols completed so far (FCH timeout check)
//   data_frame_size, coding_indicator, repition_coding_indicator,
//   subchanale_bitmap : decoded fields, updated when byte 2 arrives
//   fch_done          : high from the cycle after byte 2 is accepted
//   fch_error         : reserved bits set, or FCH missing by symbol 3
// ---------------------------------------------------------------------------
module ofdm_fch_parser
   import ofdm_frame_rx_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        active,
   input  logic        fch_valid,
   input  logic [7:0]  fch_data,
   input  logic [15:0] symbol_index,
   output logic [7:0]  data_frame_size,
   output logic [2:0]  coding_indicator,
   output logic [1:0]  repition_coding_indicator,
   output logic [5:0]  subchanale_bitmap,
   output logic        fch_done,
   output logic        fch_error
);

   logic [7:0]  byte0, byte1;
   logic [1:0]  byte_cnt;
   fch_fields_t dec;

   // byte 2 is decoded straight off the bus so fields land with fch_done
   assign dec = fch_decode(byte0, byte1, fch_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte0                     <= '0;
         byte1                     <= '0;
         byte_cnt                  <= '0;
         data_frame_size           <= '0;
         coding_indicator          <= '0;
         repition_coding_indicator <= '0;
         subchanale_bitmap         <= '0;
         fch_done                  <= 1'b0;
         fch_error                 <= 1'b0;
      end else if (clear) begin
         byte0                     <= '0;
         byte1                     <= '0;
         byte_cnt                  <= '0;
         data_frame_size           <= '0;
         coding_indicator          <= '0;
         repition_coding_indicator <= '0;
         subchanale_bitmap         <= '0;
         fch_done                  <= 1'b0;
         fch_error                 <= 1'b0;
      end else if (active) begin
         // fch_done gates capture, so bytes past the third are dropped
         if (fch_valid && !fch_done) begin
            case (byte_cnt)
               2'd0: byte0 <= fch_data;
               2'd1: byte1 <= fch_data;
               default: begin
                  data_frame_size           <= dec.data_frame_size;
                  coding_indicator          <= dec.coding_indicator;
                  repition_coding_indicator <= dec.repition_coding_indicator;
                  subchanale_bitmap         <= dec.subchanale_bitmap;
                  fch_done                  <= 1'b1;
                  if (dec.error) fch_error <= 1'b1;
               end
            endcase
            if (byte_cnt != 2'(FCH_BYTES - 1)) byte_cnt <= byte_cnt + 2'd1;
         end
         // header never arrived within the first three symbols
         if (!fch_done && symbol_index >= 16'd3) fch_error <= 1'b1;
      end
   end

endmodule

// File: rtl/ofdm_frame_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ofdm_frame_rx_ctrl
//   Receive-side frame controller: after a start pulse it drops the two
//   preambles, then for every OFDM symbol drops the cyclic prefix and
//   forwards the useful samples toward the FFT. The FCH parser tells it how
//   many data symbols follow; the frame ends when enough symbols are in or
//   the FCH is bad/missing.
//   clk, reset             : clock, async active-high reset
//   start                  : frame-detect pulse (honoured in IDLE only)
//   in_valid, in_data_i/q  : received I/Q samples
//   fch_valid, fch_data    : demapped FCH bytes
//   out_valid, out_data_i/q: CP-stripped samples, one-cycle latency
//   out_symbol_last        : marks the last sample of each symbol
//   FCH fields, fch_done, fch_error : from the FCH parser
//   symbol_index           : symbols completed in this frame
//   done_receive           : one-cycle pulse while in DONE
//   o_state                : current state encoding
// ---------------------------------------------------------------------------
module ofdm_frame_rx_ctrl
   import ofdm_frame_rx_ctrl_pkg::*;
#(
   parameter int DATA_SIZE     = 16,
   parameter int SYMBOLS_SIZE  = 256,
   parameter int CP_LENGHT     = 8,
   parameter int PREAMBLE_SIZE = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] in_data_i,
   input  logic [DATA_SIZE-1:0] in_data_q,
   input  logic                 fch_valid,
   input  logic [7:0]           fch_data,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data_i,
   output logic [DATA_SIZE-1:0] out_data_q,
   output logic                 out_symbol_last,
   output logic [7:0]           data_frame_size,
   output logic [2:0]           coding_indicator,
   output logic [1:0]           repition_coding_indicator,
   output logic [5:0]           subchanale_bitmap,
   output logic                 fch_done,
   output logic                 fch_error,
   output logic [15:0]          symbol_index,
   output logic                 done_receive,
   output logic [2:0]           o_state
);

   localparam int CNT_W = $clog2(2*PREAMBLE_SIZE + SYMBOLS_SIZE + CP_LENGHT);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(2*PREAMBLE_SIZE - 1);
   localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'(CP_LENGHT - 1);
   localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOLS_SIZE - 1);

   rx_state_t        state;
   logic [CNT_W-1:0] sample_cnt;
   logic             start_acc;
   logic             abort;
   logic [15:0]      sym_next;
   logic [16:0]      frame_need;

   assign o_state    = state;
   assign start_acc  = (state == ST_IDLE) && start;
   // a bad or missing FCH kills the frame from any in-frame state
   assign abort      = fch_error && (state == ST_PREAMBLE || state == ST_CP ||
                                     state == ST_SYMBOL);
   assign sym_next   = symbol_index + 16'd1;
   // FCH symbol plus data_frame_size data symbols
   assign frame_need = {9'd0, data_frame_size} + 17'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         sample_cnt      <= '0;
         symbol_index    <= '0;
         out_valid       <= 1'b0;
         out_symbol_last <= 1'b0;
         out_data_i      <= '0;
         out_data_q      <= '0;
         done_receive    <= 1'b0;
      end else begin
         out_valid       <= 1'b0;
         out_symbol_last <= 1'b0;
         done_receive    <= 1'b0;
         if (abort) begin
            state        <= ST_DONE;
            done_receive <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     state        <= ST_PREAMBLE;
                     sample_cnt   <= '0;
                     symbol_index <= '0;
                  end
               end
               ST_PREAMBLE: begin
                  if (in_valid) begin
                     if (sample_cnt == PRE_LAST) begin
                        state      <= ST_CP;
                        sample_cnt <= '0;
                     end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_CP: begin
                  // FCH completed after the last needed symbol already ended
                  if (fch_done && {1'b0, symbol_index} >= frame_need) begin
                     state        <= ST_DONE;
                     done_receive <= 1'b1;
                  end else if (in_valid) begin
                     if (sample_cnt == CP_LAST) begin
                        state      <= ST_SYMBOL;
                        sample_cnt <= '0;
                     end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_SYMBOL: begin
                  if (in_valid) begin
                     out_valid  <= 1'b1;
                     out_data_i <= in_data_i;
                     out_data_q <= in_data_q;
                     if (sample_cnt == SYM_LAST) begin
                        out_symbol_last <= 1'b1;
                        symbol_index    <= sym_next;
                        sample_cnt      <= '0;
                        // fch_done here is the value before this cycle
                        if (fch_done && {1'b0, sym_next} >= frame_need) begin
                           state        <= ST_DONE;
                           done_receive <= 1'b1;
                        end else begin
                           state <= ST_CP;
                        end
                     end else begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   ofdm_fch_parser u_fch_parser (
      .clk                       (clk),
      .reset                     (reset),
      .clear                     (start_acc),
      .active                    (state != ST_IDLE),
      .fch_valid                 (fch_valid),
      .fch_data                  (fch_data),
      .symbol_index              (symbol_index),
      .data_frame_size           (data_frame_size),
      .coding_indicator          (coding_indicator),
      .repition_coding_indicator (repition_coding_indicator),
      .subchanale_bitmap         (subchanale_bitmap),
      .fch_done                  (fch_done),
      .fch_error                 (fch_error)
   );

endmodule

// File: tb/tb_ofdm_frame_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ofdm_frame_rx_ctrl
//   Table of frame vectors plus hand-written corner sequences and random
//   frames. Expected samples come from the stream of driven samples and the
//   frame arithmetic: symbol k's useful samples are valid-sample indices
//   512 + 264*k + 8 .. +255, and a good frame carries max(size+1, s+1)
//   symbols, s being the symbol in which the FCH finished.
// ---------------------------------------------------------------------------
module tb_ofdm_frame_rx_ctrl;

   localparam int PRE    = 512;
   localparam int CPL    = 8;
   localparam int SYM    = 256;
   localparam int SPAN   = CPL + SYM;
   localparam int BUDGET = 20000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data_i = '0, in_data_q = '0;
   logic        fch_valid = 1'b0;
   logic [7:0]  fch_data = '0;
   logic        out_valid, out_symbol_last, fch_done, fch_error, done_receive;
   logic [15:0] out_data_i, out_data_q, symbol_index;
   logic [7:0]  data_frame_size;
   logic [2:0]  coding_indicator, o_state;
   logic [1:0]  repition_coding_indicator;
   logic [5:0]  subchanale_bitmap;

   always #5 clk = ~clk;

   ofdm_frame_rx_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data_i(in_data_i), .in_data_q(in_data_q),
      .fch_valid(fch_valid), .fch_data(fch_data),
      .out_valid(out_valid), .out_data_i(out_data_i), .out_data_q(out_data_q),
      .out_symbol_last(out_symbol_last), .data_frame_size(data_frame_size),
      .coding_indicator(coding_indicator),
      .repition_coding_indicator(repition_coding_indicator),
      .subchanale_bitmap(subchanale_bitmap), .fch_done(fch_done),
      .fch_error(fch_error), .symbol_index(symbol_index),
      .done_receive(done_receive), .o_state(o_state)
   );

   int tests = 0;
   int fails = 0;

   logic [31:0] sent_q[$];
   logic [31:0] got_q[$];
   int  n_last, n_done, n_bad, cyc, err_cyc, dst_cyc;
   bit  mon_en = 1'b0;

   // output monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mon_en) begin
         if (out_valid) begin
            got_q.push_back({out_data_i, out_data_q});
            if (out_symbol_last) begin
               n_last++;
               if (got_q.size() % SYM != 0) n_bad++;
            end
         end else if (out_symbol_last) begin
            n_bad++;
         end
         if (done_receive) begin
            n_done++;
            if (o_state != 3'd4) n_bad++;
         end
         if (fch_error && err_cyc < 0) err_cyc = cyc;
         if (o_state == 3'd4 && dst_cyc < 0) dst_cyc = cyc;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Drive one frame; returns early (mid-frame) when rst_cyc is reached.
   task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit has_fch,
                            input int fch_at, input int mode,
                            input bit start_mid, input int rst_cyc);
      int vcount, fb;
      bit v;
      sent_q.delete(); got_q.delete();
      n_last = 0; n_done = 0; n_bad = 0; err_cyc = -1; dst_cyc = -1;
      mon_en = 1'b1; vcount = 0; fb = -1;
      start = 1'b1; in_valid = 1'b1;            // start-cycle sample is not counted
      in_data_i = 16'($urandom); in_data_q = 16'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
         if (rst_cyc >= 0 && c == rst_cyc) return;
         if (n_done != 0) break;
         case (mode)
            0:       v = 1'b1;
            1:       v = (c % 2 == 0);
            default: v = ($urandom_range(3) != 0);
         endcase
         in_valid  = v;
         in_data_i = 16'($urandom);
         in_data_q = 16'($urandom);
         if (v) sent_q.push_back({in_data_i, in_data_q});
         if (has_fch && fb < 0 && vcount == fch_at) fb = 0;
         if (fb >= 0 && fb < 3) begin
            fch_valid = 1'b1;
            fch_data  = (fb == 0) ? b0 : (fb == 1) ? b1 : b2;
            fb++;
         end else begin
            fch_valid = 1'b0;
         end
         start = start_mid && (c == 700);
         if (v) vcount++;
         @(posedge clk); #1;
      end
      start = 1'b0; in_valid = 1'b0; fch_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      mon_en = 1'b0;
   endtask

   task automatic chk_stream(input string nm, input int nsym, input int nexp);
      int bad;
      bad = 0;
      chk({nm, ".out_count"}, got_q.size(), nexp);
      for (int i = 0; i < got_q.size() && i < nexp; i++) begin
         int idx;
         idx = PRE + (i / SYM) * SPAN + CPL + (i % SYM);
         if (idx >= sent_q.size() || i / SYM >= nsym) bad++;
         else if (got_q[i] !== sent_q[idx]) bad++;
      end
      chk({nm, ".out_data_bad"}, bad, 0);
   endtask

   task automatic chk_frame(input string nm, input int e_dfs, input int e_ci,
                            input int e_rci, input int e_bm, input int e_n);
      chk({nm, ".dfs"}, data_frame_size, e_dfs);
      chk({nm, ".ci"}, coding_indicator, e_ci);
      chk({nm, ".rci"}, repition_coding_indicator, e_rci);
      chk({nm, ".bitmap"}, subchanale_bitmap, e_bm);
      chk({nm, ".fch_done"}, fch_done, 1);
      chk({nm, ".fch_error"}, fch_error, 0);
      chk({nm, ".symbol_index"}, symbol_index, e_n);
      chk({nm, ".done_pulses"}, n_done, 1);
      chk({nm, ".symbol_last"}, n_last, e_n);
      chk({nm, ".protocol_bad"}, n_bad, 0);
      chk({nm, ".state_idle"}, o_state, 0);
      chk_stream(nm, e_n, e_n * SYM);
   endtask

   typedef struct {
      logic [7:0] b0, b1, b2;
      int fch_at;
      int mode;
      bit start_mid;
      int e_dfs, e_ci, e_rci, e_bm, e_n;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{8'h00, 8'h10, 8'h00, PRE+SPAN+CPL+100, 0, 1'b0, 1, 0, 0, 0, 2};
      vecs[1] = '{8'h00, 8'h10, 8'h00, PRE+SPAN+CPL+100, 1, 1'b0, 1, 0, 0, 0, 2};
      vecs[2] = '{8'hBF, 8'h0F, 8'h00, PRE+CPL+20,       0, 1'b1, 0, 7, 3, 63, 1};
      vecs[3] = '{8'h80, 8'h24, 8'h00, PRE+CPL+20,       0, 1'b0, 2, 2, 1, 0, 3};
      vecs[4] = '{8'h15, 8'h31, 8'h00, PRE+SPAN+CPL+100, 2, 1'b0, 3, 0, 2, 21, 4};

      // reset state
      #1;
      chk("rst.state", o_state, 0);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.symbol_last", out_symbol_last, 0);
      chk("rst.symbol_index", symbol_index, 0);
      chk("rst.fch_done", fch_done, 0);
      chk("rst.fch_error", fch_error, 0);
      chk("rst.done_receive", done_receive, 0);
      chk("rst.dfs", data_frame_size, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // table-driven frames
      foreach (vecs[i]) begin
         run_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, 1'b1, vecs[i].fch_at,
                   vecs[i].mode, vecs[i].start_mid, -1);
         chk_frame($sformatf("vec%0d", i), vecs[i].e_dfs, vecs[i].e_ci,
                   vecs[i].e_rci, vecs[i].e_bm, vecs[i].e_n);
      end

      // reserved bit set: abort mid-symbol 0 after 103 forwarded samples
      run_frame(8'h40, 8'h00, 8'h00, 1'b1, PRE+CPL+100, 0, 1'b0, -1);
      chk("err.fch_error", fch_error, 1);
      chk("err.fch_done", fch_done, 1);
      chk("err.done_lat", dst_cyc - err_cyc, 1);
      chk("err.done_pulses", n_done, 1);
      chk("err.symbol_last", n_last, 0);
      chk("err.symbol_index", symbol_index, 0);
      chk("err.protocol_bad", n_bad, 0);
      chk_stream("err", 1, 103);

      // no FCH: error once three symbols are complete
      run_frame(8'h00, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0, -1);
      chk("nofch.fch_error", fch_error, 1);
      chk("nofch.fch_done", fch_done, 0);
      chk("nofch.symbol_index", symbol_index, 3);
      chk("nofch.symbol_last", n_last, 3);
      chk("nofch.done_pulses", n_done, 1);
      chk("nofch.protocol_bad", n_bad, 0);
      chk_stream("nofch", 3, 3 * SYM);

      // random frames against the frame arithmetic
      for (int r = 0; r < 6; r++) begin
         logic [7:0] b0, b1, b2;
         int s, off, mode, e_dfs, e_n;
         b0 = {1'($urandom_range(1)), 1'b0, 6'($urandom_range(63))};
         b1 = {4'($urandom_range(3)), 4'($urandom_range(15))};
         b2 = 8'h00;
         s = $urandom_range(1); off = $urandom_range(250); mode = $urandom_range(2);
         e_dfs = (b2 % 16) * 16 + b1 / 16;
         e_n = (e_dfs + 1 > s + 1) ? e_dfs + 1 : s + 1;
         run_frame(b0, b1, b2, 1'b1, PRE + s * SPAN + CPL + off, mode, 1'b0, -1);
         chk_frame($sformatf("rnd%0d", r), e_dfs, (b1 / 2) % 8,
                   (b1 % 2) * 2 + b0 / 128, b0 % 64, e_n);
      end

      // size 255 frame, reset while in symbol 10
      run_frame(8'h00, 8'hF0, 8'h0F, 1'b1, PRE+CPL+50, 0, 1'b0, PRE + 10*SPAN + 100);
      chk("big.dfs", data_frame_size, 255);
      chk("big.ci", coding_indicator, 0);
      chk("big.symbol_index", symbol_index, 10);
      chk("big.fch_done", fch_done, 1);
      chk("big.fch_error", fch_error, 0);
      chk("big.state_symbol", o_state, 3);
      #2 reset = 1'b1;
      #1;
      chk("big_rst.state", o_state, 0);
      chk("big_rst.out_valid", out_valid, 0);
      chk("big_rst.out_data_i", out_data_i, 0);
      chk("big_rst.symbol_index", symbol_index, 0);
      chk("big_rst.dfs", data_frame_size, 0);
      chk("big_rst.fch_done", fch_done, 0);
      chk("big_rst.bitmap", subchanale_bitmap, 0);
      chk("big_rst.done_receive", done_receive, 0);
      start = 1'b0; in_valid = 1'b0; fch_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("big_rst.no_done", n_done, 0);
      chk("big_rst.idle", o_state, 0);
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
